// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter sizing helper
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: DIGIT-bit ripple chain of fulladder cells
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_i,
  output logic s,
  output logic c_o
);
  assign s   = a ^ b ^ c_i;
  assign c_o = (a & b) | (c_i & (a ^ b));
endmodule

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             carry_i,
  output logic [DIGIT-1:0] sum,
  output logic             carry_o
);
  logic [DIGIT:0] c;
  assign c[0]    = carry_i;
  assign carry_o = c[DIGIT];
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fulladder u_fa (.a(a[i]), .b(b[i]), .c_i(c[i]), .s(sum[i]), .c_o(c[i+1]));
  end
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/sub, LSB digit first; SERIAL_ADDER_OVERFLOW_EN adds overflow_o
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             valid_o,
  input  logic             ready_i
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow_o
`endif
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic c_q, c_d, ready_q, ready_d, valid_q, valid_d;
  logic [DIGIT-1:0] dsum;
  logic dcar;
  logic [WIDTH+DIGIT-1:0] cat;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
  assign overflow_o = ovf_q;
`endif
  // operands shift right so the active digit always sits in the low bits
  digit_adder #(.DIGIT(DIGIT)) u_add (
    .a(a_q[DIGIT-1:0]), .b(b_q[DIGIT-1:0]), .carry_i(c_q), .sum(dsum), .carry_o(dcar)
  );
  assign cat      = {dsum, res_q};
  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = res_q;
  assign carry_o  = c_q;
  // next-state: accept in IDLE, one digit per CALC cycle, hold in DONE until consumed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == IDLE && ready_q && valid_i) begin
      state_d = CALC;
      cnt_d   = '0;
      a_d     = a_i;
      b_d     = sub_i ? ~b_i : b_i;
      c_d     = sub_i | carry_i;
    end else if (state_q == CALC) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      res_d = cat[WIDTH+DIGIT-1:DIGIT];
      c_d   = dcar;
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? DONE : CALC;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_d = (cnt_q == LAST) ? (a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dcar) : ovf_q;
`endif
    end else if (state_q == DONE && ready_i) begin
      state_d = IDLE;
    end
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end
  // state and datapath registers; handshake outputs registered so reset drives them low
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder against an arithmetic model
module tb_serial_adder;
  localparam int W = 32;
  localparam int D = 4;
  localparam int N = W / D;
  logic clk = 1'b0;
  logic rst_i, rst_s;
  logic [W-1:0] a_i, b_i, result_o;
  logic carry_i, sub_i, valid_i, ready_o, carry_o, valid_o, ready_i;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic overflow_o;
  bit exp_ov;
`endif
  int nvec = 0, errs = 0, cyc = 0, acc_cyc = 0, done_cnt = 0;
  bit pending = 0;
  logic pv = 1'b0;
  logic [W:0] exp_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sub_i(sub_i),
    .valid_i(valid_i), .ready_o(ready_o), .result_o(result_o), .carry_o(carry_o),
    .valid_o(valid_o), .ready_i(ready_i)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow_o(overflow_o)
`endif
  );

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned expv);
    nvec++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // {carry, result} of the operation as plain unsigned arithmetic
  function automatic longint unsigned model(input int w, input longint unsigned a, input longint unsigned b,
                                            input bit c, input bit s);
    longint unsigned m = (64'd1 << w) - 1;
    if (s) return ((a - b) & m) | ((a >= b ? 64'd1 : 64'd0) << w);
    return a + b + (c ? 64'd1 : 64'd0);
  endfunction

  // signed overflow: true signed result falls outside the w-bit range
  function automatic bit ovf_model(input int w, input longint unsigned a, input longint unsigned b,
                                   input bit c, input bit s);
    longint sa, sb, r, hi;
    hi = longint'(1) << (w - 1);
    sa = (a >= 64'(hi)) ? longint'(a) - (hi <<< 1) : longint'(a);
    sb = (b >= 64'(hi)) ? longint'(b) - (hi <<< 1) : longint'(b);
    r = s ? sa - sb : sa + sb + (c ? 1 : 0);
    return (r > hi - 1) || (r < -hi);
  endfunction

  // compare process: whenever a result is presented it must match the model and stay put
  always @(negedge clk) begin
    if (valid_o) begin
      chk("unexpected_valid", pending, 1);
      chk("result", {carry_o, result_o}, exp_r);
      chk("ready_in_done", ready_o, 0);
      if (!pv) chk("latency", cyc - acc_cyc, N);
`ifdef SERIAL_ADDER_OVERFLOW_EN
      chk("overflow", overflow_o, exp_ov);
`endif
    end
    pv <= valid_o;
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit c, input bit s, input int hold);
    int t;
    @(negedge clk);
    t = 0;
    while (!ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", ready_o, 1);
    a_i = a; b_i = b; carry_i = c; sub_i = s; valid_i = 1;
    exp_r = (W + 1)'(model(W, a, b, c, s));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    exp_ov = ovf_model(W, a, b, c, s);
`endif
    @(posedge clk);
    #1 valid_i = 0;
    acc_cyc = cyc;
    pending = 1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!valid_o && t < 50);
    chk("valid_wait", valid_o, 1);
    repeat (hold) begin
      @(negedge clk);
      a_i = $urandom; b_i = $urandom; valid_i = 1'($urandom_range(0, 1));
    end
    valid_i = 0;
    ready_i = 1;
    @(posedge clk);
    #1 ready_i = 0;
    pending = 0;
    @(negedge clk);
    chk("valid_drop", valid_o, 0);
    chk("ready_back", ready_o, 1);
  endtask

  // WIDTH=4 instances for DIGIT=1,2,4, each swept exhaustively on its own reset
  for (genvar g = 0; g < 3; g++) begin : g_small
    localparam int SD = 1 << g;
    logic [3:0] sa, sb, sr;
    logic sc, ss, sv, sro, sco, svo, sri;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic sov;
`endif
    serial_adder #(.WIDTH(4), .DIGIT(SD)) u_s (
      .clk_i(clk), .rst_i(rst_s), .a_i(sa), .b_i(sb), .carry_i(sc), .sub_i(ss),
      .valid_i(sv), .ready_o(sro), .result_o(sr), .carry_o(sco), .valid_o(svo), .ready_i(sri)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      , .overflow_o(sov)
`endif
    );
    initial begin
      int lat, t;
      sa = 0; sb = 0; sc = 0; ss = 0; sv = 0; sri = 0;
      wait (rst_s == 1'b0);
      for (int x = 0; x < 1024; x++) begin
        @(negedge clk);
        t = 0;
        while (!sro && t < 20) begin
          @(negedge clk);
          t++;
        end
        chk("small_ready", sro, 1);
        sa = x[3:0]; sb = x[7:4]; sc = x[8]; ss = x[9]; sv = 1;
        @(posedge clk);
        #1 sv = 0;
        lat = 0;
        do begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end while (!svo && lat < 16);
        chk("small_latency", lat, 4 / SD);
        chk("small_result", {sco, sr}, model(4, sa, sb, sc, ss));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("small_overflow", sov, ovf_model(4, sa, sb, sc, ss));
`endif
        sri = 1;
        @(posedge clk);
        #1 sri = 0;
      end
      done_cnt++;
    end
  end

  initial begin
    int t;
    rst_i = 1; rst_s = 1;
    a_i = 0; b_i = 0; carry_i = 0; sub_i = 0; valid_i = 0; ready_i = 0;
    chk("pin_add_wrap", model(W, 64'hFFFF_FFFF, 1, 0, 0), 64'h1_0000_0000);
    chk("pin_sub_neg", model(W, 5, 7, 1, 1), 64'h0_FFFF_FFFE);
    chk("pin_sub_pos", model(W, 7, 5, 1, 1), 64'h1_0000_0002);
    chk("pin_add_plain", model(W, 64'h1234_5678, 64'h1111_1111, 0, 0), 64'h0_2345_6789);
    chk("pin_ovf_add", ovf_model(W, 64'h7FFF_FFFF, 1, 0, 0), 1);
    chk("pin_ovf_sub", ovf_model(W, 64'h8000_0000, 1, 0, 1), 1);
    chk("pin_ovf_none", ovf_model(W, 3, 4, 0, 0), 0);
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_carry", carry_o, 0);
    rst_i = 0; rst_s = 0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", ready_o, 1);
    do_op(32'hFFFF_FFFF, 32'h1, 0, 0, 0);
    do_op(32'd5, 32'd7, 1, 1, 0);
    do_op(32'd7, 32'd5, 0, 1, 5);
    // abort an operation on its third CALC cycle
    @(negedge clk);
    a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D; carry_i = 1; sub_i = 0; valid_i = 1;
    @(posedge clk);
    #1 valid_i = 0;
    repeat (2) @(posedge clk);
    #2 rst_i = 1;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_result", result_o, 0);
    @(negedge clk);
    rst_i = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_after", ready_o, 1);
    do_op(32'h1234_5678, 32'h1111_1111, 0, 0, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    do_op(32'h7FFF_FFFF, 32'h1, 0, 0, 0);
    do_op(32'h8000_0000, 32'h1, 0, 1, 0);
    do_op(32'd3, 32'd4, 0, 0, 0);
`endif
    for (int i = 0; i < 30; i++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    t = 0;
    while (done_cnt < 3 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("small_done", done_cnt, 3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
